// File: rtl/wishbone_dual_pkg.sv
// Shared constants, master FSM state type and beat-count helpers for wishbone_dual.
package wishbone_dual_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StStb,
    StGap,
    StDone
  } master_state_e;

  // Number of bus beats that make up one wide external word.
  function automatic int unsigned nbeats(input int unsigned ext_w, input int unsigned data_w);
    return ext_w / data_w;
  endfunction

  // Width of a beat counter; never narrower than one bit.
  function automatic int unsigned beat_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wishbone_dual_master.sv
// Wishbone classic-cycle master: turns a request edge into an N-beat single-word burst and
// packs read beats into (or unpacks write beats from) a wide word.
module wishbone_dual_master
  import wishbone_dual_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned EXT_RW_WIDTH = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // External request side
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_read_i,
  input  logic [ADDR_WIDTH-1:0]   addr_write_i,
  input  logic [EXT_RW_WIDTH-1:0] wdata_i,
  output logic [EXT_RW_WIDTH-1:0] rdata_o,
  output logic                    read_done_o,
  output logic                    write_done_o,
  // Wishbone master side
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i
);

  localparam int unsigned NBeats = nbeats(EXT_RW_WIDTH, DATA_WIDTH);
  localparam int unsigned BeatW  = beat_width(NBeats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);

  master_state_e           state_q;
  logic                    req_q;
  logic                    op_we_q;
  logic [BeatW-1:0]        beat_q;
  logic                    cyc_q;
  logic                    stb_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [EXT_RW_WIDTH-1:0] rdata_q;
  logic                    read_done_q;
  logic                    write_done_q;

  logic [ADDR_WIDTH-1:0]   base;

  assign base = op_we_q ? addr_write_i : addr_read_i;

  // Burst sequencer: STB waits for ack, GAP drops stb for a cycle so a late ack is not recounted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      op_we_q      <= 1'b0;
      beat_q       <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      rdata_q      <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      req_q <= req_i;
      case (state_q)
        StIdle: begin
          if (req_i && !req_q) begin
            op_we_q <= we_i;
            beat_q  <= '0;
            if (we_i) begin
              write_done_q <= 1'b0;
              adr_q        <= addr_write_i;
            end else begin
              read_done_q <= 1'b0;
              adr_q       <= addr_read_i;
            end
            dat_q   <= wdata_i[DATA_WIDTH-1:0];
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= StStb;
          end
        end
        StStb: begin
          if (ack_i) begin
            if (!op_we_q) begin
              rdata_q[DATA_WIDTH*beat_q +: DATA_WIDTH] <= dat_i;
            end
            stb_q <= 1'b0;
            if (beat_q == LastBeat) begin
              cyc_q   <= 1'b0;
              adr_q   <= '0;
              dat_q   <= '0;
              state_q <= StDone;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          // beat_q already points at the next beat here.
          stb_q   <= 1'b1;
          adr_q   <= base + (ADDR_WIDTH'(beat_q) << 2);
          dat_q   <= wdata_i[DATA_WIDTH*beat_q +: DATA_WIDTH];
          state_q <= StStb;
        end
        StDone: begin
          if (op_we_q) begin
            write_done_q <= 1'b1;
          end else begin
            read_done_q <= 1'b1;
          end
          op_we_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cyc_o        = cyc_q;
  assign stb_o        = stb_q;
  assign we_o         = op_we_q & cyc_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign sel_o        = {(DATA_WIDTH/8){cyc_q}};
  assign rdata_o      = rdata_q;
  assign read_done_o  = read_done_q;
  assign write_done_o = write_done_q;

endmodule

// File: rtl/wishbone_dual.sv
// Dual-role Wishbone bridge: an independent master (request-driven N-beat bursts) and a slave
// that captures N write beats into a wide word and serves N read beats from a wide word.
module wishbone_dual
  import wishbone_dual_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned EXT_RW_WIDTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // Wishbone slave
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_ack_o,
  // Wishbone master
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_ack_i,
  // External master interface
  input  logic                    ext_master_req,
  input  logic                    ext_master_we,
  input  logic [ADDR_WIDTH-1:0]   ext_master_addr_read,
  input  logic [ADDR_WIDTH-1:0]   ext_master_addr_write,
  input  logic [EXT_RW_WIDTH-1:0] ext_master_wdata,
  output logic [EXT_RW_WIDTH-1:0] ext_master_rdata,
  output logic                    ext_master_read_done,
  output logic                    ext_master_write_done,
  // External slave interface
  input  logic [EXT_RW_WIDTH-1:0] ext_slave_wdata,
  output logic [EXT_RW_WIDTH-1:0] ext_slave_rdata,
  output logic                    ext_slave_we,
  output logic                    ext_slave_read_done,
  output logic                    ext_slave_write_done,
  output logic [ADDR_WIDTH-1:0]   ext_slave_addr_read,
  output logic [ADDR_WIDTH-1:0]   ext_slave_addr_write
);

  localparam int unsigned NBeats = nbeats(EXT_RW_WIDTH, DATA_WIDTH);
  localparam int unsigned BeatW  = beat_width(NBeats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);

  // Full-word transfers only; byte selects and burst hints carry no information here.
  logic unused_wbs_hints;
  assign unused_wbs_hints = ^{wbs_sel_i, wbs_cti_i, wbs_bte_i};

  wishbone_dual_master #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .EXT_RW_WIDTH(EXT_RW_WIDTH)
  ) u_master (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (ext_master_req),
    .we_i        (ext_master_we),
    .addr_read_i (ext_master_addr_read),
    .addr_write_i(ext_master_addr_write),
    .wdata_i     (ext_master_wdata),
    .rdata_o     (ext_master_rdata),
    .read_done_o (ext_master_read_done),
    .write_done_o(ext_master_write_done),
    .cyc_o       (wbm_cyc_o),
    .stb_o       (wbm_stb_o),
    .we_o        (wbm_we_o),
    .adr_o       (wbm_adr_o),
    .dat_o       (wbm_dat_o),
    .sel_o       (wbm_sel_o),
    .dat_i       (wbm_dat_i),
    .ack_i       (wbm_ack_i)
  );

  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BTE_LINEAR;

  logic                    s_ack_q;
  logic [DATA_WIDTH-1:0]   s_dat_q;
  logic [BeatW-1:0]        s_beat_q;
  logic                    s_we_q;
  logic [EXT_RW_WIDTH-1:0] s_rdata_q;
  logic                    s_read_done_q;
  logic                    s_write_done_q;
  logic [ADDR_WIDTH-1:0]   s_addr_read_q;
  logic [ADDR_WIDTH-1:0]   s_addr_write_q;

  // Slave: one-cycle ack per accepted beat; beat index is internal, the bus address only
  // records where a burst started. Dropping cyc restarts the count but keeps captured data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_ack_q        <= 1'b0;
      s_dat_q        <= '0;
      s_beat_q       <= '0;
      s_we_q         <= 1'b0;
      s_rdata_q      <= '0;
      s_read_done_q  <= 1'b0;
      s_write_done_q <= 1'b0;
      s_addr_read_q  <= '0;
      s_addr_write_q <= '0;
    end else begin
      s_ack_q <= 1'b0;
      if (!wbs_cyc_i) begin
        s_beat_q <= '0;
      end else if (wbs_stb_i && !s_ack_q) begin
        s_ack_q <= 1'b1;
        if (s_beat_q == '0) begin
          s_we_q <= wbs_we_i;
          if (wbs_we_i) begin
            s_addr_read_q <= wbs_adr_i;
            s_read_done_q <= 1'b0;
          end else begin
            s_addr_write_q <= wbs_adr_i;
            s_write_done_q <= 1'b0;
          end
        end
        if (wbs_we_i) begin
          s_rdata_q[DATA_WIDTH*s_beat_q +: DATA_WIDTH] <= wbs_dat_i;
        end else begin
          s_dat_q <= ext_slave_wdata[DATA_WIDTH*s_beat_q +: DATA_WIDTH];
        end
        if (s_beat_q == LastBeat) begin
          s_beat_q <= '0;
          if (wbs_we_i) begin
            s_read_done_q <= 1'b1;
          end else begin
            s_write_done_q <= 1'b1;
          end
        end else begin
          s_beat_q <= s_beat_q + 1'b1;
        end
      end
    end
  end

  assign wbs_ack_o            = s_ack_q;
  assign wbs_dat_o            = s_dat_q;
  assign ext_slave_rdata      = s_rdata_q;
  assign ext_slave_we         = s_we_q;
  assign ext_slave_read_done  = s_read_done_q;
  assign ext_slave_write_done = s_write_done_q;
  assign ext_slave_addr_read  = s_addr_read_q;
  assign ext_slave_addr_write = s_addr_write_q;

endmodule

// File: tb/tb_wishbone_dual.sv
// Self-checking bench for wishbone_dual: table-driven slave bursts plus hand-written master,
// reset-abort and concurrency sequences.
module tb_wishbone_dual;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 256;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [AW-1:0] wbs_adr_i = '0;
  logic [DW-1:0] wbs_dat_i = '0;
  logic [3:0]    wbs_sel_i = 4'hF;
  logic [2:0]    wbs_cti_i = '0;
  logic [1:0]    wbs_bte_i = '0;
  logic [DW-1:0] wbs_dat_o;
  logic          wbs_ack_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [3:0]    wbm_sel_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;
  logic          ext_master_req = 0, ext_master_we = 0;
  logic [AW-1:0] ext_master_addr_read = '0, ext_master_addr_write = '0;
  logic [EW-1:0] ext_master_wdata = '0;
  logic [EW-1:0] ext_master_rdata;
  logic          ext_master_read_done, ext_master_write_done;
  logic [EW-1:0] ext_slave_wdata = '0;
  logic [EW-1:0] ext_slave_rdata;
  logic          ext_slave_we, ext_slave_read_done, ext_slave_write_done;
  logic [AW-1:0] ext_slave_addr_read, ext_slave_addr_write;

  wishbone_dual #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .EXT_RW_WIDTH(EW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wbs_cyc_i            (wbs_cyc_i),
    .wbs_stb_i            (wbs_stb_i),
    .wbs_we_i             (wbs_we_i),
    .wbs_adr_i            (wbs_adr_i),
    .wbs_dat_i            (wbs_dat_i),
    .wbs_sel_i            (wbs_sel_i),
    .wbs_cti_i            (wbs_cti_i),
    .wbs_bte_i            (wbs_bte_i),
    .wbs_dat_o            (wbs_dat_o),
    .wbs_ack_o            (wbs_ack_o),
    .wbm_cyc_o            (wbm_cyc_o),
    .wbm_stb_o            (wbm_stb_o),
    .wbm_we_o             (wbm_we_o),
    .wbm_adr_o            (wbm_adr_o),
    .wbm_dat_o            (wbm_dat_o),
    .wbm_sel_o            (wbm_sel_o),
    .wbm_cti_o            (wbm_cti_o),
    .wbm_bte_o            (wbm_bte_o),
    .wbm_dat_i            (wbm_dat_i),
    .wbm_ack_i            (wbm_ack_i),
    .ext_master_req       (ext_master_req),
    .ext_master_we        (ext_master_we),
    .ext_master_addr_read (ext_master_addr_read),
    .ext_master_addr_write(ext_master_addr_write),
    .ext_master_wdata     (ext_master_wdata),
    .ext_master_rdata     (ext_master_rdata),
    .ext_master_read_done (ext_master_read_done),
    .ext_master_write_done(ext_master_write_done),
    .ext_slave_wdata      (ext_slave_wdata),
    .ext_slave_rdata      (ext_slave_rdata),
    .ext_slave_we         (ext_slave_we),
    .ext_slave_read_done  (ext_slave_read_done),
    .ext_slave_write_done (ext_slave_write_done),
    .ext_slave_addr_read  (ext_slave_addr_read),
    .ext_slave_addr_write (ext_slave_addr_write)
  );

  // Bus slave model for the master side: acks one cycle after stb, returns A0000000 + beat.
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_dat = '0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] log_adr[64];
  logic [DW-1:0] log_dat[64];
  logic          log_we[64];
  logic [3:0]    log_sel[64];
  int            log_n = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_ack <= 1'b0;
      m_dat <= '0;
    end else begin
      m_ack <= wbm_cyc_o && wbm_stb_o && !m_ack;
      if (wbm_cyc_o && wbm_stb_o && !m_ack) begin
        m_dat <= 32'hA000_0000 + ((wbm_adr_o - m_base) >> 2);
        if (log_n < 64) begin
          log_adr[log_n] <= wbm_adr_o;
          log_dat[log_n] <= wbm_dat_o;
          log_we[log_n]  <= wbm_we_o;
          log_sel[log_n] <= wbm_sel_o;
        end
        log_n <= log_n + 1;
      end
    end
  end

  assign wbm_ack_i = m_ack;
  assign wbm_dat_i = m_dat;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic master_start(input logic we, input logic [AW-1:0] base, input int hold);
    @(negedge clk);
    m_base        = base;
    ext_master_we = we;
    if (we) ext_master_addr_write = base;
    else    ext_master_addr_read  = base;
    ext_master_req = 1'b1;
    repeat (hold) @(negedge clk);
    ext_master_req = 1'b0;
  endtask

  task automatic master_wait(input logic we);
    int n;
    n = 0;
    while (!(we ? ext_master_write_done : ext_master_read_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(we ? "master_wr_done" : "master_rd_done",
          EW'(we ? ext_master_write_done : ext_master_read_done), EW'(1));
  endtask

  task automatic check_master_read(input logic [AW-1:0] base, input int s);
    logic [EW-1:0] exp;
    check("mrd_beat_count", EW'(log_n - s), EW'(NB));
    for (int i = 0; i < NB; i++) begin
      exp[DW*i +: DW] = 32'hA000_0000 + i;
      if (s + i < 64) begin
        check("mrd_adr", EW'(log_adr[s+i]), EW'(base + 4 * i));
        check("mrd_we_sel", EW'({log_we[s+i], log_sel[s+i]}), EW'(5'b0_1111));
      end
    end
    check("mrd_rdata", ext_master_rdata, exp);
  endtask

  task automatic slave_beat(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            output logic [DW-1:0] rd);
    int n;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs_ack_o && n < 20);
    check("s_ack_seen", EW'(wbs_ack_o), EW'(1));
    rd        = wbs_dat_o;
    wbs_stb_i = 1'b0;
    @(negedge clk);
    check("s_ack_one_cycle", EW'(wbs_ack_o), EW'(0));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          tbl[16];
  logic [DW-1:0] serve[NB];
  logic [DW-1:0] wwords[NB];

  initial begin
    logic [DW-1:0] rd;
    logic [EW-1:0] exp;
    int s;

    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [EW-1:0] exp;
    int            s;
    int            n;

    serve  = '{32'hBA69B24A, 32'h13AD27BD, 32'h5E5E0001, 32'h77665544,
               32'h0F0F0F0F, 32'h12345678, 32'h9ABCDEF0, 32'hAB123456};
    wwords = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233,
               32'hFACEB00C, 32'hBEEF1234, 32'hDEADBEEF, 32'hCAFEBABE};
    for (int i = 0; i < NB; i++) begin
      tbl[i].we          = 1'b1;
      tbl[i].adr         = 32'h3000 + 4 * i;
      tbl[i].wdat        = 32'hA000_0000 + i;
      tbl[i].exp_rd      = '0;
      tbl[NB+i].we       = 1'b0;
      tbl[NB+i].adr      = 32'h4000 + 4 * i;
      tbl[NB+i].wdat     = '0;
      tbl[NB+i].exp_rd   = serve[i];
      ext_slave_wdata[DW*i +: DW]  = serve[i];
      ext_master_wdata[DW*i +: DW] = wwords[i];
    end

    repeat (3) @(negedge clk);
    check("reset_wbm", EW'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), '0);
    check("reset_wbs", EW'({wbs_ack_o, wbs_dat_o}), '0);
    check("reset_flags", EW'({ext_master_read_done, ext_master_write_done, ext_slave_we,
                              ext_slave_read_done, ext_slave_write_done}), '0);
    check("reset_const", EW'({wbm_cti_o, wbm_bte_o}), '0);
    rst = 1'b1;
    @(negedge clk);

    // Master read, single-cycle request pulse.
    s = log_n;
    master_start(1'b0, 32'h1000, 1);
    master_wait(1'b0);
    check_master_read(32'h1000, s);

    // Master write, request held across several cycles must not retrigger.
    s = log_n;
    master_start(1'b1, 32'h2000, 5);
    master_wait(1'b1);
    repeat (20) @(negedge clk);
    check("mwr_beat_count", EW'(log_n - s), EW'(NB));
    for (int i = 0; i < NB; i++) begin
      check("mwr_adr", EW'(log_adr[s+i]), EW'(32'h2000 + 4 * i));
      check("mwr_dat", EW'(log_dat[s+i]), EW'(wwords[i]));
      check("mwr_we", EW'(log_we[s+i]), EW'(1));
    end
    check("mwr_rd_done_sticky", EW'(ext_master_read_done), EW'(1));
    check("mwr_idle_bus", EW'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), '0);

    // Slave capture then slave serve from the vector table.
    @(negedge clk);
    for (int i = 0; i < 2 * NB; i++) begin
      slave_beat(tbl[i].we, tbl[i].adr, tbl[i].wdat, rd);
      if (!tbl[i].we) check("s_rd_dat", EW'(rd), EW'(tbl[i].exp_rd));
      if (i == NB - 1 || i == 2 * NB - 1) begin
        wbs_cyc_i = 1'b0;
        @(negedge clk);
      end
      if (i == NB - 1) begin
        exp = '0;
        for (int k = 0; k < NB; k++) exp[DW*k +: DW] = 32'hA000_0000 + k;
        check("s_cap_rdata", ext_slave_rdata, exp);
        check("s_cap_addr", EW'(ext_slave_addr_read), EW'(32'h3000));
        check("s_cap_we_done", EW'({ext_slave_we, ext_slave_read_done}), EW'(2'b11));
      end
      if (i == 2 * NB - 1) begin
        check("s_srv_addr", EW'(ext_slave_addr_write), EW'(32'h4000));
        check("s_srv_we_done", EW'({ext_slave_we, ext_slave_write_done}), EW'(2'b01));
        check("s_srv_cap_kept", EW'(ext_slave_read_done), EW'(1));
      end
    end

    // Reset in the middle of a master read, after beat 3 has been taken.
    s = log_n;
    master_start(1'b0, 32'h5000, 1);
    n = 0;
    while (log_n - s < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_beat3", EW'(log_n - s >= 4), EW'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wbm", EW'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), '0);
    check("rst_mrdata", ext_master_rdata, '0);
    check("rst_mflags", EW'({ext_master_read_done, ext_master_write_done}), '0);
    check("rst_srdata", ext_slave_rdata, '0);
    check("rst_sregs", EW'({ext_slave_addr_read, ext_slave_addr_write, ext_slave_we,
                            ext_slave_read_done, ext_slave_write_done, wbs_ack_o, wbs_dat_o}), '0);
    rst = 1'b1;
    @(negedge clk);
    s = log_n;
    master_start(1'b0, 32'h1000, 1);
    master_wait(1'b0);
    check_master_read(32'h1000, s);

    // Concurrent master read with a slave capture that is first aborted after 3 beats.
    s = log_n;
    fork
      begin
        master_start(1'b0, 32'h6000, 1);
        master_wait(1'b0);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) slave_beat(1'b1, 32'h7100 + 4 * i, 32'hB000_0000 + i, rd);
        wbs_cyc_i = 1'b0;
        @(negedge clk);
        check("abort_no_done", EW'(ext_slave_read_done), EW'(0));
        for (int i = 0; i < NB; i++) slave_beat(1'b1, 32'h7000 + 4 * i, 32'hC000_0000 + i, rd);
        wbs_cyc_i = 1'b0;
        @(negedge clk);
      end
    join
    check_master_read(32'h6000, s);
    exp = '0;
    for (int k = 0; k < NB; k++) exp[DW*k +: DW] = 32'hC000_0000 + k;
    check("conc_s_rdata", ext_slave_rdata, exp);
    check("conc_s_addr", EW'(ext_slave_addr_read), EW'(32'h7000));
    check("conc_s_done", EW'(ext_slave_read_done), EW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wishbone_dual.md
Name: wishbone_dual

Overview:
Dual-role Wishbone B4 classic-cycle bridge between a fuzzer-facing wide-word interface and a Wishbone bus.
- Master side: on an external request, performs an N-beat single-word read or write burst and packs or unpacks a wide word.
- Slave side: accepts N bus write beats into a wide capture register, and serves N bus read beats from a wide external word.
- Master and slave sides are fully independent and may operate concurrently.

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; must be a multiple of 8
EXT_RW_WIDTH, 256, external word width; must be a multiple of DATA_WIDTH; NBEATS = EXT_RW_WIDTH/DATA_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  slave cycle, strobe, write-enable
wbs_adr_i  in  ADDR_WIDTH  slave address
wbs_dat_i  in  DATA_WIDTH  slave write data
wbs_sel_i  in  DATA_WIDTH/8  byte select; ignored, full-word transfers only
wbs_cti_i  in  3  cycle type; ignored
wbs_bte_i  in  2  burst type; ignored
wbs_dat_o  out  DATA_WIDTH  slave read data
wbs_ack_o  out  1  slave acknowledge
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  master cycle, strobe, write-enable
wbm_adr_o  out  ADDR_WIDTH  master address
wbm_dat_o  out  DATA_WIDTH  master write data
wbm_sel_o  out  DATA_WIDTH/8  all ones while cyc is high
wbm_cti_o  out  3  000 (classic cycle)
wbm_bte_o  out  2  00
wbm_dat_i  in  DATA_WIDTH  master read data
wbm_ack_i  in  1  master acknowledge
ext_master_req  in  1  start request; rising edge triggers
ext_master_we  in  1  0 = bus read, 1 = bus write; sampled at start
ext_master_addr_read  in  ADDR_WIDTH  read base address
ext_master_addr_write  in  ADDR_WIDTH  write base address
ext_master_wdata  in  EXT_RW_WIDTH  data to write
ext_master_rdata  out  EXT_RW_WIDTH  data read from bus
ext_master_read_done  out  1  sticky read-complete flag
ext_master_write_done  out  1  sticky write-complete flag
ext_slave_wdata  in  EXT_RW_WIDTH  data served on Wishbone reads
ext_slave_rdata  out  EXT_RW_WIDTH  data captured from Wishbone writes
ext_slave_we  out  1  wbs_we_i of most recently started slave burst
ext_slave_read_done  out  1  sticky: NBEATS Wishbone writes captured
ext_slave_write_done  out  1  sticky: NBEATS Wishbone reads served
ext_slave_addr_read  out  ADDR_WIDTH  beat-0 address of last Wishbone-write burst
ext_slave_addr_write  out  ADDR_WIDTH  beat-0 address of last Wishbone-read burst

Behaviour:
- Reset (rst==0 at a clk edge): all outputs and all internal state go to 0.
  - A transfer in progress is aborted; partial data is discarded.
- Beat packing: beat i maps to bits [DATA_WIDTH*i +: DATA_WIDTH]. Beat 0 is the LSW.
- Master start condition: a rising edge of ext_master_req while in IDLE. A held-high req never retriggers. A req edge outside IDLE is ignored.
- Master FSM states:
  - IDLE: all wbm_* outputs are 0. On a start, latch ext_master_we, set beat=0, clear the matching done flag, go to STB.
  - STB: cyc=1, stb=1, we=latched value, adr = base + 4*beat, dat_o = wdata beat.
    - An ack is accepted only while stb is high.
    - On ack of a read beat, store wbm_dat_i into rdata beat.
    - After an ack: if last beat, go to DONE; otherwise beat++ and go to GAP.
  - GAP: stb=0, cyc stays 1 for one cycle, so a stale registered ack is never double-counted. Then go to STB.
  - DONE: cyc=0, stb=0. Set read_done or write_done (sticky until the next start of the same type). Go to IDLE.
- Master latency: with a slave that acks one cycle after stb, each beat takes 3 cycles; an 8-beat burst completes in about 25 cycles.
- Slave beat acceptance: when wbs_cyc_i and wbs_stb_i are high and wbs_ack_o is 0, register a one-cycle ack.
  - Per accepted beat, ack is high for exactly one cycle.
  - No ack is given while stb is low.
- Slave beat counting: beat index comes from an internal counter; wbs_adr_i does not select the beat.
- Beat 0 of a slave burst:
  - latch wbs_we_i into ext_slave_we;
  - latch wbs_adr_i into ext_slave_addr_read (write burst) or ext_slave_addr_write (read burst);
  - clear the matching done flag.
- Slave write beat: store wbs_dat_i into ext_slave_rdata beat.
- Slave read beat: wbs_dat_o = ext_slave_wdata beat, registered and presented with ack. wbs_dat_o holds its value otherwise.
- Slave completion: after beat NBEATS-1, set read_done (write burst) or write_done (read burst), then reset the counter to 0.
- wbs_cyc_i low mid-burst: counter returns to 0, no done flag is set, captured data is retained.

Decomposition:
- Package wishbone_dual_pkg: CTI_CLASSIC (3'b000), BTE_LINEAR (2'b00), the master FSM state enum, and an NBEATS function of the parameters.
- One sub-module, wishbone_dual_master, holds the master FSM and datapath.
- Slave logic stays inline in wishbone_dual.

Test Plan:
- Master read: bench slave acks one cycle after stb and returns 0xA0000000+i on beat i; base 0x1000, we=0, one-cycle req pulse -> addresses 0x1000..0x101C; ext_master_rdata = {A0000007,...,A0000000}; ext_master_read_done=1.
- Master write: wdata = {CAFEBABE,DEADBEEF,BEEF1234,FACEB00C,00112233,44556677,8899AABB,CCDDEEFF}; base 0x2000; req held 5 cycles -> 8 writes at 0x2000..0x201C, data CCDDEEFF first and CAFEBABE last, we_o=1; exactly one burst; write_done=1.
- Slave capture: 8 Wishbone writes of 0xA0000000+i at 0x3000+4i, stb dropped between beats -> 8 single-cycle acks; ext_slave_rdata = {A0000007..A0000000}; ext_slave_addr_read=0x3000; ext_slave_we=1; ext_slave_read_done=1.
- Slave serve: ext_slave_wdata = {AB123456,...,BA69B24A}; 8 Wishbone reads at 0x4000+4i -> wbs_dat_o sequence BA69B24A, 13AD27BD, ..., AB123456; ext_slave_addr_write=0x4000; ext_slave_write_done=1.
- Reset mid-master-read after beat 3 -> all outputs 0 next cycle; a new read then completes normally.
- Concurrency plus abort: master read concurrent with slave capture -> both correct; slave cyc dropped after 3 beats -> no done; a following full burst starts from beat 0.
